// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and downstream memory port bundle.
// The arbiter uses slave; the environment (cores, memory) uses master.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int MW = DATA_WIDTH / 8;

  logic                  inst_read_i;
  logic [ADDR_WIDTH-1:0] inst_addr_i;
  logic                  inst_resp_o;
  logic [DATA_WIDTH-1:0] inst_rdata_o;

  logic                  data_read_i;
  logic                  data_write_i;
  logic [ADDR_WIDTH-1:0] data_addr_i;
  logic [DATA_WIDTH-1:0] data_wdata_i;
  logic [MW-1:0]         data_mbe_i;
  logic                  data_resp_o;
  logic [DATA_WIDTH-1:0] data_rdata_o;

  logic                  mem_read_o;
  logic                  mem_write_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [MW-1:0]         mem_mbe_o;
  logic                  mem_resp_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  inst_read_i, inst_addr_i,
    output inst_resp_o, inst_rdata_o,
    input  data_read_i, data_write_i, data_addr_i,
    input  data_wdata_i, data_mbe_i,
    output data_resp_o, data_rdata_o,
    output mem_read_o, mem_write_o, mem_addr_o,
    output mem_wdata_o, mem_mbe_o,
    input  mem_resp_i, mem_rdata_i
  );

  modport master (
    output inst_read_i, inst_addr_i,
    input  inst_resp_o, inst_rdata_o,
    output data_read_i, data_write_i, data_addr_i,
    output data_wdata_i, data_mbe_i,
    input  data_resp_o, data_rdata_o,
    input  mem_read_o, mem_write_o, mem_addr_o,
    input  mem_wdata_o, mem_mbe_o,
    output mem_resp_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store.
// Define MEM_ARB_FAIR_EN to alternate priority on fetch/data ties.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fls_i,
  mem_port_arbiter_if.slave bus
);
  localparam int MW = DATA_WIDTH / 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] INST = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MW-1:0]         mbe_q, mbe_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  drop_q, drop_d;
  logic                  data_pend, inst_pend;
  logic                  pick_data, grant;
  logic                  inst_ok, data_ok;

  assign data_pend = bus.data_read_i | bus.data_write_i;
  assign inst_pend = bus.inst_read_i & ~fls_i;
  assign grant     = (state_q == IDLE) & (data_pend | inst_pend);

`ifdef MEM_ARB_FAIR_EN
  // Set when data won the last grant; fetch then wins the next tie.
  logic last_q;
  assign pick_data = data_pend & ~(inst_pend & last_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last_q <= 1'b0;
    else if (grant) last_q <= pick_data;
  end
`else
  assign pick_data = data_pend;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mbe_d   = mbe_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    drop_d  = drop_q;
    unique case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (pick_data) begin
          state_d = DATA;
          addr_d  = bus.data_addr_i;
          wdata_d = bus.data_wdata_i;
          mbe_d   = bus.data_mbe_i;
          wr_d    = bus.data_write_i;
          rd_d    = ~bus.data_write_i;
        end else if (inst_pend) begin
          state_d = INST;
          addr_d  = bus.inst_addr_i;
          wdata_d = '0;
          mbe_d   = '1;
          rd_d    = 1'b1;
          wr_d    = 1'b0;
        end
      end
      INST: begin
        drop_d = drop_q | fls_i;
        if (bus.mem_resp_i) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          drop_d  = 1'b0;
        end
      end
      DATA: begin
        if (bus.mem_resp_i) begin
          state_d = IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        drop_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      mbe_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mbe_q   <= mbe_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      drop_q  <= drop_d;
    end
  end

  // A flush landing on the response cycle squashes it too.
  assign inst_ok = (state_q == INST) & bus.mem_resp_i
                 & ~drop_q & ~fls_i;
  assign data_ok = (state_q == DATA) & bus.mem_resp_i;

  assign bus.inst_resp_o  = inst_ok;
  assign bus.inst_rdata_o = inst_ok ? bus.mem_rdata_i : '0;
  assign bus.data_resp_o  = data_ok;
  assign bus.data_rdata_o = data_ok ? bus.mem_rdata_i : '0;

  assign bus.mem_read_o  = rd_q;
  assign bus.mem_write_o = wr_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.mem_mbe_o   = mbe_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a request-level arbitration model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fls = 1'b0;

  int checks   = 0;
  int errors   = 0;
  int inst_cnt = 0;
  int data_cnt = 0;
  bit last_data = 1'b0;

  bit          s_ok, s_wr, s_ir, s_dr;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wd, s_ird, s_drd;
  logic [MW-1:0] s_be;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .fls_i (fls),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference arbitration rule: data wins unless fairness hands a tie to fetch.
  function automatic bit pick_data(bit dp, bit ip, bit last);
    if (!dp) return 1'b0;
    if (!ip) return 1'b1;
`ifdef MEM_ARB_FAIR_EN
    return !last;
`else
    return 1'b1;
`endif
  endfunction

  // Response exclusivity and zero-when-idle rdata, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    #3;
    if (bus.inst_resp_o === 1'b1) inst_cnt++;
    if (bus.data_resp_o === 1'b1) data_cnt++;
    checks++;
    if ((bus.inst_resp_o === 1'b1 && bus.data_resp_o === 1'b1) ||
        (bus.inst_resp_o !== 1'b1 && bus.inst_rdata_o !== '0) ||
        (bus.data_resp_o !== 1'b1 && bus.data_rdata_o !== '0)) begin
      errors++;
      $display("FAIL resp_excl: ir=%b irdata=%h dr=%b drdata=%h, required exclusive resp and zero idle rdata",
               bus.inst_resp_o, bus.inst_rdata_o, bus.data_resp_o, bus.data_rdata_o);
    end
  end

  task automatic clear_inputs();
    bus.inst_read_i  = 1'b0;
    bus.inst_addr_i  = '0;
    bus.data_read_i  = 1'b0;
    bus.data_write_i = 1'b0;
    bus.data_addr_i  = '0;
    bus.data_wdata_i = '0;
    bus.data_mbe_i   = '0;
    bus.mem_resp_i   = 1'b0;
    bus.mem_rdata_i  = '0;
    fls = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_data = 1'b0;
  endtask

  // Act as memory: wait for a request, hold lat cycles, respond once.
  task automatic serve(input int lat, input logic [DW-1:0] rdata);
    int n = 0;
    s_ok = 0; s_ir = 0; s_dr = 0; s_ird = '0; s_drd = '0;
    s_addr = '0; s_wr = 0; s_wd = '0; s_be = '0;
    while (!(bus.mem_read_o || bus.mem_write_o) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL grant_timeout: no request after %0d cycles, required one", n);
      return;
    end
    s_ok   = 1;
    s_addr = bus.mem_addr_o;
    s_wr   = bus.mem_write_o;
    s_wd   = bus.mem_wdata_o;
    s_be   = bus.mem_mbe_o;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_addr_o !== s_addr ||
          (bus.mem_read_o | bus.mem_write_o) !== 1'b1) begin
        errors++;
        $display("FAIL hold: addr=%h rd=%b wr=%b, required addr=%h held with request",
                 bus.mem_addr_o, bus.mem_read_o, bus.mem_write_o, s_addr);
      end
    end
    bus.mem_resp_i  = 1'b1;
    bus.mem_rdata_i = rdata;
    #1;
    s_ir  = bus.inst_resp_o;
    s_dr  = bus.data_resp_o;
    s_ird = bus.inst_rdata_o;
    s_drd = bus.data_rdata_o;
    @(negedge clk);
    bus.mem_resp_i  = 1'b0;
    bus.mem_rdata_i = '0;
    checks++;
    if (bus.mem_read_o !== 1'b0 || bus.mem_write_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_resp: rd=%b wr=%b, required 0 0",
               bus.mem_read_o, bus.mem_write_o);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.mem_read_o, bus.mem_write_o, bus.mem_addr_o, bus.mem_wdata_o,
         bus.mem_mbe_o, bus.inst_resp_o, bus.data_resp_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rd=%b wr=%b addr=%h wd=%h be=%h, required all zero",
               bus.mem_read_o, bus.mem_write_o, bus.mem_addr_o,
               bus.mem_wdata_o, bus.mem_mbe_o);
    end
    rst = 1'b0;
    @(negedge clk);
    bus.mem_resp_i  = 1'b1;
    bus.mem_rdata_i = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (bus.inst_resp_o !== 1'b0 || bus.data_resp_o !== 1'b0 ||
        bus.data_rdata_o !== '0) begin
      errors++;
      $display("FAIL idle_stray_resp: ir=%b dr=%b drdata=%h, required 0 0 0",
               bus.inst_resp_o, bus.data_resp_o, bus.data_rdata_o);
    end
    @(negedge clk);
    bus.mem_resp_i  = 1'b0;
    bus.mem_rdata_i = '0;
  endtask

  task automatic test_fetch();
    int c0;
    do_reset();
    c0 = inst_cnt;
    bus.inst_read_i = 1'b1;
    bus.inst_addr_i = 32'h60;
    serve(3, 32'h0000_0013);
    bus.inst_read_i = 1'b0;
    checks++;
    if (s_addr !== 32'h60 || s_wr !== 1'b0) begin
      errors++;
      $display("FAIL fetch_addr: addr=%h wr=%b, required 00000060 0", s_addr, s_wr);
    end
    checks++;
    if (s_ir !== 1'b1 || s_dr !== 1'b0 || s_ird !== 32'h13) begin
      errors++;
      $display("FAIL fetch_resp: ir=%b dr=%b rdata=%h, required 1 0 00000013",
               s_ir, s_dr, s_ird);
    end
    @(negedge clk);
    checks++;
    if (inst_cnt - c0 !== 1) begin
      errors++;
      $display("FAIL fetch_pulse: %0d resp cycles, required 1", inst_cnt - c0);
    end
  endtask

  task automatic test_priority();
    do_reset();
    bus.inst_read_i  = 1'b1;
    bus.inst_addr_i  = 32'h64;
    bus.data_write_i = 1'b1;
    bus.data_addr_i  = 32'h1000;
    bus.data_wdata_i = 32'hDEAD_BEEF;
    bus.data_mbe_i   = 4'hF;
    serve(1, 32'h0);
    bus.data_write_i = 1'b0;
    checks++;
    if (s_addr !== 32'h1000 || s_wr !== 1'b1 || s_wd !== 32'hDEAD_BEEF ||
        s_be !== 4'hF || s_dr !== 1'b1 || s_ir !== 1'b0) begin
      errors++;
      $display("FAIL prio_store: addr=%h wr=%b wd=%h be=%h dr=%b ir=%b, required 00001000 1 deadbeef f 1 0",
               s_addr, s_wr, s_wd, s_be, s_dr, s_ir);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_read_o !== 1'b1 || bus.mem_addr_o !== 32'h64) begin
      errors++;
      $display("FAIL prio_fetch_next: rd=%b addr=%h, required 1 00000064",
               bus.mem_read_o, bus.mem_addr_o);
    end
    serve(0, 32'hCAFE_0001);
    bus.inst_read_i = 1'b0;
    checks++;
    if (s_ir !== 1'b1 || s_ird !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL prio_fetch_resp: ir=%b rdata=%h, required 1 cafe0001", s_ir, s_ird);
    end
  endtask

  task automatic test_tie();
`ifdef MEM_ARB_FAIR_EN
    bit exp_order [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    bit exp_order [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    bit got;
    do_reset();
    bus.inst_read_i = 1'b1;
    bus.inst_addr_i = 32'h3000;
    bus.data_read_i = 1'b1;
    bus.data_addr_i = 32'h2000;
    for (int i = 0; i < 4; i++) begin
      serve(1, 32'hA000_0000 + 32'(i));
      got = (s_addr == bus.data_addr_i);
      if (got) bus.data_addr_i = bus.data_addr_i + 32'h4;
      else     bus.inst_addr_i = bus.inst_addr_i + 32'h4;
      checks++;
      if (got !== exp_order[i] || s_dr !== exp_order[i]) begin
        errors++;
        $display("FAIL tie_order[%0d]: data_won=%b dr=%b, required %b",
                 i, got, s_dr, exp_order[i]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_flush();
    int c0;
    do_reset();
    bus.inst_read_i = 1'b1;
    bus.inst_addr_i = 32'h80;
    fls = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.mem_read_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_blocks_grant: rd=%b, required 0", bus.mem_read_o);
    end
    fls = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_read_o !== 1'b1 || bus.mem_addr_o !== 32'h80) begin
      errors++;
      $display("FAIL flush_regrant: rd=%b addr=%h, required 1 00000080",
               bus.mem_read_o, bus.mem_addr_o);
    end
    c0 = inst_cnt;
    fls = 1'b1;
    bus.inst_read_i = 1'b0;
    @(negedge clk);
    fls = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.mem_read_o !== 1'b1 || bus.mem_addr_o !== 32'h80) begin
      errors++;
      $display("FAIL flush_hold: rd=%b addr=%h, required 1 00000080",
               bus.mem_read_o, bus.mem_addr_o);
    end
    bus.mem_resp_i  = 1'b1;
    bus.mem_rdata_i = 32'h1234;
    #1;
    checks++;
    if (bus.inst_resp_o !== 1'b0 || bus.inst_rdata_o !== '0) begin
      errors++;
      $display("FAIL flush_drop: ir=%b rdata=%h, required 0 0",
               bus.inst_resp_o, bus.inst_rdata_o);
    end
    @(negedge clk);
    bus.mem_resp_i  = 1'b0;
    bus.mem_rdata_i = '0;
    checks++;
    if (bus.mem_read_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: rd=%b, required 0", bus.mem_read_o);
    end
    bus.inst_read_i = 1'b1;
    bus.inst_addr_i = 32'h84;
    @(negedge clk);
    checks++;
    if (bus.mem_read_o !== 1'b1) begin
      errors++;
      $display("FAIL flush2_grant: rd=%b, required 1", bus.mem_read_o);
    end
    @(negedge clk);
    bus.mem_resp_i  = 1'b1;
    bus.mem_rdata_i = 32'h5678;
    fls = 1'b1;
    bus.inst_read_i = 1'b0;
    #1;
    checks++;
    if (bus.inst_resp_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_same_cycle: ir=%b, required 0", bus.inst_resp_o);
    end
    @(negedge clk);
    bus.mem_resp_i  = 1'b0;
    bus.mem_rdata_i = '0;
    fls = 1'b0;
    checks++;
    if (inst_cnt !== c0 || bus.mem_read_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_count: resps=%0d rd=%b, required %0d 0",
               inst_cnt, bus.mem_read_o, c0);
    end
    bus.inst_read_i = 1'b1;
    bus.inst_addr_i = 32'h88;
    serve(1, 32'h55);
    bus.inst_read_i = 1'b0;
    checks++;
    if (s_ir !== 1'b1 || s_ird !== 32'h55) begin
      errors++;
      $display("FAIL flush_recover: ir=%b rdata=%h, required 1 00000055", s_ir, s_ird);
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    do_reset();
    bus.data_read_i = 1'b1;
    bus.data_addr_i = 32'h200;
    @(negedge clk);
    checks++;
    if (bus.mem_read_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_grant: rd=%b, required 1", bus.mem_read_o);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.data_read_i = 1'b0;
    #1;
    checks++;
    if ({bus.mem_read_o, bus.mem_write_o, bus.mem_addr_o,
         bus.mem_wdata_o, bus.mem_mbe_o} !== '0) begin
      errors++;
      $display("FAIL rstmid_clear: rd=%b addr=%h, required all zero",
               bus.mem_read_o, bus.mem_addr_o);
    end
    @(negedge clk);
    rst = 1'b0;
    last_data = 1'b0;
    c0 = data_cnt;
    @(negedge clk);
    bus.mem_resp_i  = 1'b1;
    bus.mem_rdata_i = 32'hABCD;
    #1;
    checks++;
    if (bus.data_resp_o !== 1'b0 || bus.data_rdata_o !== '0 ||
        bus.inst_resp_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_stray: dr=%b drdata=%h ir=%b, required 0 0 0",
               bus.data_resp_o, bus.data_rdata_o, bus.inst_resp_o);
    end
    @(negedge clk);
    bus.mem_resp_i  = 1'b0;
    bus.mem_rdata_i = '0;
    checks++;
    if (data_cnt !== c0 || bus.mem_read_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_quiet: resps=%0d rd=%b, required %0d 0",
               data_cnt - c0, bus.mem_read_o, 0);
    end
  endtask

  task automatic test_random();
    bit ip, dp, drd, dwr, win;
    int k, kind, lat;
    logic [AW-1:0] ia, da;
    logic [DW-1:0] wd, rdv, exp_rd;
    logic [MW-1:0] be;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      k    = int'($urandom_range(1, 3));
      kind = int'($urandom_range(0, 2));
      ip   = (k != 2);
      dp   = (k != 1);
      drd  = (kind != 1);
      dwr  = (kind != 0);
      ia   = {$urandom} & 32'hFFFF_FFFC;
      da   = {$urandom} & 32'hFFFF_FFFC;
      wd   = $urandom;
      be   = MW'($urandom);
      bus.inst_read_i  = ip;
      bus.inst_addr_i  = ia;
      bus.data_read_i  = dp & drd;
      bus.data_write_i = dp & dwr;
      bus.data_addr_i  = da;
      bus.data_wdata_i = wd;
      bus.data_mbe_i   = be;
      while (ip || dp) begin
        win = pick_data(dp, ip, last_data);
        rdv = $urandom;
        lat = int'($urandom_range(0, 4));
        serve(lat, rdv);
        checks++;
        if (s_addr !== (win ? da : ia) || s_wr !== (win & dwr)) begin
          errors++;
          $display("FAIL rnd_grant[%0d]: addr=%h wr=%b, required %h %b",
                   it, s_addr, s_wr, win ? da : ia, win & dwr);
        end
        if (win && dwr) begin
          checks++;
          if (s_wd !== wd || s_be !== be) begin
            errors++;
            $display("FAIL rnd_wdata[%0d]: wd=%h be=%h, required %h %h",
                     it, s_wd, s_be, wd, be);
          end
        end
        checks++;
        if (s_dr !== win || s_ir !== !win) begin
          errors++;
          $display("FAIL rnd_route[%0d]: dr=%b ir=%b, required %b %b",
                   it, s_dr, s_ir, win, !win);
        end
        exp_rd = rdv;
        checks++;
        if ((win ? s_drd : s_ird) !== exp_rd) begin
          errors++;
          $display("FAIL rnd_rdata[%0d]: got %h, required %h",
                   it, win ? s_drd : s_ird, exp_rd);
        end
        last_data = win;
        if (win) begin
          dp = 1'b0;
          bus.data_read_i  = 1'b0;
          bus.data_write_i = 1'b0;
        end else begin
          ip = 1'b0;
          bus.inst_read_i = 1'b0;
        end
      end
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_tie();
    test_flush();
    test_reset_mid();
    test_random();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width; mbe width is DATA_WIDTH/8.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port fls_i  input  1  pipeline flush from the reorder buffer.
REQ-006 SHALL have ports inst_read_i (in, 1) and inst_addr_i (in, ADDR_WIDTH): fetch request, level-held until inst_resp_o.
REQ-007 SHALL have ports inst_resp_o (out, 1) and inst_rdata_o (out, DATA_WIDTH): fetch completion and data.
REQ-008 SHALL have ports data_read_i, data_write_i (in, 1), data_addr_i (in, ADDR_WIDTH), data_wdata_i (in, DATA_WIDTH), data_mbe_i (in, DATA_WIDTH/8): load/store request, level-held until data_resp_o.
REQ-009 SHALL have ports data_resp_o (out, 1) and data_rdata_o (out, DATA_WIDTH): load/store completion and data.
REQ-010 SHALL have ports mem_read_o, mem_write_o (out, 1), mem_addr_o (out, ADDR_WIDTH), mem_wdata_o (out, DATA_WIDTH), mem_mbe_o (out, DATA_WIDTH/8): shared downstream port.
REQ-011 SHALL have ports mem_resp_i (in, 1) and mem_rdata_i (in, DATA_WIDTH): downstream completion and data.

Function
REQ-012 SHALL implement FSM states IDLE, INST, DATA; exactly one transaction outstanding downstream.
REQ-013 IDLE: data_read_i|data_write_i pending -> DATA; else inst_read_i pending and fls_i low -> INST; else stay IDLE.
REQ-014 On grant, SHALL latch addr/wdata/mbe/read/write of the winner into registers; mem_* outputs driven only from these registers.
REQ-015 mem_read_o/mem_write_o SHALL be asserted from the cycle after grant until the cycle mem_resp_i is seen; deasserted in IDLE.
REQ-016 data_read_i and data_write_i both high SHALL be treated as write.
REQ-017 In INST/DATA with mem_resp_i high: SHALL pulse the owning requester's resp for exactly that cycle, pass mem_rdata_i combinationally to its rdata, return to IDLE next cycle.
REQ-018 Minimum grant-to-grant spacing SHALL be two cycles (one IDLE cycle between transactions).
REQ-019 fls_i high in INST, or in the same cycle as its mem_resp_i, SHALL set a drop flag; transaction still completes downstream, inst_resp_o suppressed; flag cleared on return to IDLE.
REQ-020 fls_i SHALL NOT affect DATA transactions (stores must complete).
REQ-021 mem_resp_i in IDLE SHALL be ignored.
REQ-022 inst_resp_o and data_resp_o SHALL never be high in the same cycle; *_rdata_o SHALL be zero when the matching resp is low.

Reset
REQ-023 rst SHALL force IDLE, clear drop flag and fairness flag, zero all mem_* registers, asynchronously.
REQ-024 Reset mid-transaction SHALL abandon it; no resp generated for it; a later stray mem_resp_i is ignored per REQ-021.

Configuration
REQ-025 Macro MEM_ARB_FAIR_EN: when defined, a last-grant flag SHALL alternate priority when inst and data are both pending in IDLE (winner loses next tie); when undefined, data SHALL always win ties (REQ-013).

Verification
REQ-026 Fetch only, addr 0x60, mem_resp_i 3 cycles after mem_read_o, rdata 0x00000013 -> inst_resp_o one cycle, inst_rdata_o 0x00000013, mem_addr_o 0x60 throughout.
REQ-027 Fetch 0x64 and store 0x1000 wdata 0xDEADBEEF mbe 0xF raised same cycle, FAIR undefined -> store granted first, fetch granted after one IDLE cycle.
REQ-028 Both pending continuously for 4 transactions with MEM_ARB_FAIR_EN -> grant order data, inst, data, inst.
REQ-029 fls_i pulsed mid-fetch -> mem_read_o held until mem_resp_i, inst_resp_o never asserts, FSM IDLE next cycle.
REQ-030 rst asserted mid-load, mem_resp_i arrives after release -> all outputs zero, no data_resp_o.
